// File: rtl/uart_rx_arb_pkg.sv
// Shared definitions for the UART RX read-port arbiter: FSM encodings,
// default widths and the requester-index width helper.
package uart_rx_arb_pkg;

    localparam int STATE_W    = 4;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_rr_picker.sv
// Combinational round-robin picker: first asserted request found searching
// upward from (last_gnt + 1) mod N_REQ with wrap-around.
module uart_rx_rr_picker
    import uart_rx_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_gnt,
    output logic             any_req,
    output logic [IW-1:0]    winner
);

    logic [IW:0]   sum  [N_REQ];
    logic [IW-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[gi] is the requester examined at search position gi; the sum is
    // below 2*N_REQ, so a single conditional subtraction performs the wrap.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, last_gnt} + (IW+1)'(gi + 1);
            assign cand[gi] = (sum[gi] >= (IW+1)'(N_REQ))
                              ? IW'(sum[gi] - (IW+1)'(N_REQ))
                              : sum[gi][IW-1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        logic found;
        found   = 1'b0;
        winner  = '0;
        any_req = |req;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && hit[i]) begin
                winner = cand[i];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// Round-robin arbiter sharing the UART RX data-read port, one byte per grant.
// Optional WAIT-state watchdog enabled by defining UART_RX_ARB_TIMEOUT_EN.
module uart_rx_arbiter
    import uart_rx_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DW          = DEFAULT_DW,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [DW-1:0]    rdata_o,
    output logic             busy_o,
    output logic             uart_rd_en_o,
    input  logic             uart_rx_empty_i,
    input  logic [DW-1:0]    uart_rdata_i,
    input  logic             uart_rvalid_i,
    output logic             err_o
);

    localparam int            IW       = idx_w(N_REQ);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

    state_t        state_reg, state_next;
    logic [IW-1:0] gnt_idx_reg;
    logic [IW-1:0] last_gnt_reg;
    logic [DW-1:0] rdata_reg;
    logic [IW-1:0] winner;
    logic          any_req;
    logic          grant_take;
    logic          timeout_hit;

    uart_rx_rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req      (req_i),
        .last_gnt (last_gnt_reg),
        .any_req  (any_req),
        .winner   (winner)
    );

    assign grant_take = (state_reg == S_IDLE) && any_req && !uart_rx_empty_i;

`ifdef UART_RX_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] to_cnt_reg;
    logic       err_reg;

    // Fires in the TIMEOUT_CYC-th WAIT cycle, so the ack lands exactly
    // TIMEOUT_CYC cycles after WAIT was entered.
    assign timeout_hit = (state_reg == S_WAIT) && !uart_rvalid_i && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg == S_ISSUE) begin
                to_cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                to_cnt_reg <= to_cnt_reg + 8'd1;
            end
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_o = err_reg;
`else
    logic [7:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 8'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
    assign err_o              = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // req_i is only looked at in IDLE, so a request held through DONE is
    // re-arbitrated against everyone else rather than renewed automatically.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant_take) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (uart_rvalid_i || timeout_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gnt_idx_reg  <= '0;
            last_gnt_reg <= LAST_RST;
            rdata_reg    <= '0;
        end else begin
            if (grant_take) begin
                gnt_idx_reg <= winner;
            end
            if (state_reg == S_DONE) begin
                last_gnt_reg <= gnt_idx_reg;
            end
            if (state_reg == S_WAIT) begin
                if (uart_rvalid_i) begin
                    rdata_reg <= uart_rdata_i;
                end else if (timeout_hit) begin
                    rdata_reg <= '0;
                end
            end
        end
    end

    // Outputs decode the registered state, so reset clears them at once.
    assign uart_rd_en_o = (state_reg == S_ISSUE);
    assign busy_o       = (state_reg != S_IDLE);
    assign rdata_o      = rdata_reg;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack_o[gi] = (state_reg == S_DONE) && (gnt_idx_reg == IW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Directed self-checking bench for uart_rx_arbiter (N_REQ=2) with a small
// behavioural RX FIFO responding two cycles after each read-enable.
module tb_uart_rx_arbiter;

    localparam int N_REQ = 2;
    localparam int DW    = 8;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic [N_REQ-1:0] req_i = '0;
    logic [N_REQ-1:0] ack_o;
    logic [DW-1:0]    rdata_o;
    logic             busy_o;
    logic             uart_rd_en_o;
    logic             uart_rx_empty_i = 1'b1;
    logic [DW-1:0]    uart_rdata_i = '0;
    logic             uart_rvalid_i = 1'b0;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo[$];
    logic [7:0] pend_byte = '0;
    int         pend_cnt = 0;
    int         rd_en_count = 0;
    logic       resp_mute = 1'b0;
    logic       stray_req = 1'b0;
    logic [7:0] stray_byte = '0;

    uart_rx_arbiter #(
        .N_REQ       (N_REQ),
        .DW          (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .req_i           (req_i),
        .ack_o           (ack_o),
        .rdata_o         (rdata_o),
        .busy_o          (busy_o),
        .uart_rd_en_o    (uart_rd_en_o),
        .uart_rx_empty_i (uart_rx_empty_i),
        .uart_rdata_i    (uart_rdata_i),
        .uart_rvalid_i   (uart_rvalid_i),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    // RX FIFO model: pop on read-enable, return the byte two cycles later.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            uart_rvalid_i = 1'b0;
            if (stray_req) begin
                uart_rvalid_i = 1'b1;
                uart_rdata_i  = stray_byte;
                stray_req     = 1'b0;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0 && !resp_mute) begin
                    uart_rvalid_i = 1'b1;
                    uart_rdata_i  = pend_byte;
                end
            end
            if (uart_rd_en_o) begin
                rd_en_count++;
                pend_byte = (fifo.size() > 0) ? fifo.pop_front() : 8'h00;
                pend_cnt  = 2;
            end
            uart_rx_empty_i = (fifo.size() == 0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         base;
        int         n;
        int         ack_cyc [4];
        logic [1:0] ack_log [4];
        logic [7:0] dat_log [4];
        logic       saw_busy;
        logic       saw_ack;
        int         to_cyc;
        logic [1:0] to_ack;
        logic [7:0] to_dat;
        logic       to_err;

        // Reset state
        tick();
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_rdata", 32'(rdata_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_rd_en", 32'(uart_rd_en_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        tick();
        rstn_i = 1'b1;

        // Single byte 0xA5 to requester 0; latency 1/3/4, idle from cycle 5
        fifo.push_back(8'hA5);
        tick();
        req_i = 2'b01;
        tick();
        chk("t1_rd_en_c1", 32'(uart_rd_en_o), 32'h1);
        chk("t1_busy_c1", 32'(busy_o), 32'h1);
        tick();
        chk("t1_rd_en_c2", 32'(uart_rd_en_o), 32'h0);
        tick();
        chk("t1_ack_c3", 32'(ack_o), 32'h0);
        tick();
        chk("t1_ack_c4", 32'(ack_o), 32'h1);
        chk("t1_rdata_c4", 32'(rdata_o), 32'hA5);
        req_i = 2'b00;
        tick();
        chk("t1_busy_c5", 32'(busy_o), 32'h0);
        chk("t1_ack_c5", 32'(ack_o), 32'h0);
        chk("t1_pulses", 32'(rd_en_count), 32'd1);
        $display("txn t1: single byte to requester 0 done");

        // Empty FIFO holds off requester 1 for 20 cycles
        base     = rd_en_count;
        saw_busy = 1'b0;
        saw_ack  = 1'b0;
        req_i    = 2'b10;
        for (int c = 0; c < 20; c++) begin
            tick();
            saw_busy |= busy_o;
            saw_ack  |= |ack_o;
        end
        chk("t3_no_pulse", 32'(rd_en_count - base), 32'd0);
        chk("t3_no_busy", 32'(saw_busy), 32'h0);
        chk("t3_no_ack", 32'(saw_ack), 32'h0);
        fifo.push_back(8'h77);
        tick();
        chk("t3_busy_empty_drop", 32'(busy_o), 32'h0);
        tick();
        chk("t3_rd_en_grant", 32'(uart_rd_en_o), 32'h1);
        tick();
        tick();
        tick();
        chk("t3_ack", 32'(ack_o), 32'h2);
        chk("t3_rdata", 32'(rdata_o), 32'h77);
        req_i = 2'b00;
        tick();
        $display("txn t3: held-off request granted to requester 1");

        // Stray read-done in IDLE is ignored
        stray_byte = 8'h5A;
        stray_req  = 1'b1;
        tick();
        tick();
        chk("stray_rdata", 32'(rdata_o), 32'h77);
        chk("stray_ack", 32'(ack_o), 32'h0);
        chk("stray_busy", 32'(busy_o), 32'h0);
        $display("txn stray: rvalid in IDLE ignored");

        // Both requesting continuously: alternate grants 5 cycles apart
        fifo.push_back(8'h11);
        fifo.push_back(8'h22);
        fifo.push_back(8'h33);
        fifo.push_back(8'h44);
        tick();
        base  = rd_en_count;
        n     = 0;
        req_i = 2'b11;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ack_o != 2'b00 && n < 4) begin
                ack_log[n] = ack_o;
                dat_log[n] = rdata_o;
                ack_cyc[n] = c;
                n++;
                if (n == 4) req_i = 2'b00;
            end
        end
        chk("t2_ack_count", 32'(n), 32'd4);
        chk("t2_pulses", 32'(rd_en_count - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                chk($sformatf("t2_ack%0d", k), 32'(ack_log[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("t2_data%0d", k), 32'(dat_log[k]), 32'h11 * (k + 1));
                chk($sformatf("t2_cyc%0d", k), 32'(ack_cyc[k]), 32'(4 + 5 * k));
                $display("txn t2.%0d: ack=%b data=%h cycle=%0d", k, ack_log[k], dat_log[k], ack_cyc[k]);
            end
        end

        // Asynchronous reset while in WAIT
        fifo.push_back(8'h99);
        tick();
        resp_mute = 1'b1;
        req_i     = 2'b01;
        tick();
        tick();
        chk("rw_busy_before", 32'(busy_o), 32'h1);
        #1;
        rstn_i = 1'b0;
        #1;
        chk("rw_busy", 32'(busy_o), 32'h0);
        chk("rw_rd_en", 32'(uart_rd_en_o), 32'h0);
        chk("rw_ack", 32'(ack_o), 32'h0);
        chk("rw_rdata", 32'(rdata_o), 32'h0);
        chk("rw_err", 32'(err_o), 32'h0);
        tick();
        tick();
        rstn_i    = 1'b1;
        resp_mute = 1'b0;
        base      = rd_en_count;
        fifo.push_back(8'hB1);
        req_i = 2'b11;
        tick();
        chk("rw_idle_after", 32'(busy_o), 32'h0);
        tick();
        chk("rw_rd_en", 32'(uart_rd_en_o), 32'h1);
        tick();
        tick();
        tick();
        chk("rw_first_ack", 32'(ack_o), 32'h1);
        chk("rw_first_data", 32'(rdata_o), 32'hB1);
        req_i = 2'b00;
        tick();
        chk("rw_pulses", 32'(rd_en_count - base), 32'd1);
        $display("txn reset-in-wait: first grant after reset to requester 0");

`ifdef UART_RX_ARB_TIMEOUT_EN
        // Watchdog: no read-done ever returned
        fifo.push_back(8'hC3);
        tick();
        resp_mute = 1'b1;
        req_i     = 2'b10;
        to_cyc    = 0;
        to_ack    = '0;
        to_dat    = 8'hFF;
        to_err    = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ack_o != 2'b00 && to_cyc == 0) begin
                to_cyc = c;
                to_ack = ack_o;
                to_dat = rdata_o;
                to_err = err_o;
                req_i  = 2'b00;
            end
        end
        chk("to_cycle", 32'(to_cyc), 32'd18);
        chk("to_ack", 32'(to_ack), 32'h2);
        chk("to_rdata", 32'(to_dat), 32'h0);
        chk("to_err", 32'(to_err), 32'h1);
        chk("to_err_sticky", 32'(err_o), 32'h1);
        chk("to_idle", 32'(busy_o), 32'h0);
        rstn_i = 1'b0;
        #1;
        chk("to_err_reset", 32'(err_o), 32'h0);
        tick();
        rstn_i    = 1'b1;
        resp_mute = 1'b0;
        $display("txn timeout: ack at cycle %0d err=%b", to_cyc, to_err);
`else
        chk("err_tied_low", 32'(err_o), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_arbiter.md
Name: uart_rx_arbiter

Overview:
- Shares the single UART RX data-read port (FIFO pop, 8-bit read data, read-done pulse) between N_REQ requesters, e.g. CPU bus slave and a DMA channel.
- Round-robin grant; one byte per grant.
- Generates the one-cycle read-enable pulse the RX block requires, waits for its read-done pulse, and returns the byte and an ack to the winner.
- Sits between the register/DMA masters and the UART RX top.

Parameters:
- N_REQ, 2, number of requesters (legal 2..8)
- DW, 8, read-data width
- TIMEOUT_CYC, 16, WAIT-state watchdog limit in cycles (used only with the optional feature; legal 4..255)

Ports:
- clk_i  input  1  system clock, rising edge
- rstn_i  input  1  asynchronous active-low reset
- req_i  input  N_REQ  per-requester level request: "want one byte"
- ack_o  output  N_REQ  one-cycle pulse: byte delivered to that requester
- rdata_o  output  DW  byte returned; valid while ack_o is high, held until next ack
- busy_o  output  1  high in any state other than S_IDLE
- uart_rd_en_o  output  1  one-cycle read-enable pulse to the RX data-read port
- uart_rx_empty_i  input  1  RX FIFO empty status
- uart_rdata_i  input  DW  RX read data
- uart_rvalid_i  input  1  RX read-done pulse
- err_o  output  1  sticky timeout flag (optional feature only; tie 0 otherwise)

Behaviour:
- Reset (asynchronous, rstn_i low): ack_o=0, rdata_o=0, busy_o=0, uart_rd_en_o=0, err_o=0, last_gnt=N_REQ-1, gnt_idx=0, state=S_IDLE.
- States, one-hot 4 bits: S_IDLE=0001, S_ISSUE=0010, S_WAIT=0100, S_DONE=1000.
- S_IDLE:
  - If |req_i and !uart_rx_empty_i: pick the winner round-robin, searching from (last_gnt+1) mod N_REQ upward with wrap. Latch gnt_idx and go to S_ISSUE.
  - Otherwise stay.
  - With the FIFO empty, requests stay pending and no pulse is issued.
- S_ISSUE: uart_rd_en_o=1 for exactly this cycle, then S_WAIT. Never more than one enable per grant, so no double pop.
- S_WAIT:
  - On uart_rvalid_i: rdata_o<=uart_rdata_i, then S_DONE.
  - uart_rvalid_i outside S_WAIT is ignored.
- S_DONE:
  - ack_o[gnt_idx]=1 for this cycle only; last_gnt<=gnt_idx; then S_IDLE.
  - The requester drops req_i on the edge ending this cycle if it wants no more bytes.
  - req_i is not sampled in S_DONE, so a held request always gets a fresh arbitration.
- Latency: request sampled in S_IDLE at edge 0; uart_rd_en_o high in cycle 1; uart_rvalid_i in cycle 3; ack_o and rdata_o in cycle 4.
  - Minimum period between back-to-back bytes: 5 cycles.
- Fairness: with all requests continuously high, grants rotate 0,1,...,N_REQ-1,0.
- A requester dropping req_i mid-transaction is not cancelled: the byte is still popped and acked, and the requester discards it.
- Simultaneous request and FIFO becoming non-empty in the same cycle: the grant is taken on that edge.
- Reset mid-operation returns to the reset values. A FIFO pop already issued downstream is not replayed.

Optional Feature:
- Macro: UART_RX_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to S_WAIT and increments each S_WAIT cycle.
  - On reaching TIMEOUT_CYC without uart_rvalid_i: go to S_DONE with rdata_o<=0 and ack the winner, so the requester never hangs; set err_o=1.
  - err_o is sticky until reset.
- Undefined: no counter; S_WAIT waits indefinitely; err_o is tied 0.

Decomposition:
- Package uart_rx_arb_pkg holds:
  - state encodings S_IDLE/S_ISSUE/S_WAIT/S_DONE
  - state width 4
  - default DW=8
  - index width function clog2(N_REQ)
- Sub-module uart_rx_rr_picker: purely combinational round-robin picker.
  - Inputs: req vector, last_gnt.
  - Outputs: any_req, winner index.
  - Instantiated once in the arbiter.
- The FSM, data capture and watchdog stay in the top.

Test Plan:
- N_REQ=2, FIFO holds 0xA5, req_i=01 at edge 0 -> uart_rd_en_o high cycle 1 only; uart_rvalid_i cycle 3; ack_o=01 in cycle 4 with rdata_o=0xA5; busy_o low from cycle 5.
- FIFO holds 0x11,0x22,0x33,0x44, req_i=11 held -> acks alternate 01,10,01,10 with bytes 0x11..0x44 in order; exactly 4 enable pulses; acks 5 cycles apart.
- uart_rx_empty_i=1, req_i=10 for 20 cycles -> no uart_rd_en_o, no ack, busy_o=0. Then empty drops -> grant to requester 1 on the next edge.
- rstn_i asserted during S_WAIT -> all outputs 0 immediately (asynchronous); after release, state is S_IDLE and the first grant goes to requester 0.
- UART_RX_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, downstream never returns uart_rvalid_i -> ack to the winner 16 cycles after entering S_WAIT, rdata_o=0, err_o=1 held until reset.
- Stray uart_rvalid_i pulse in S_IDLE with rdata 0x5A -> rdata_o unchanged, no ack.
